alu_rr_sequencer: RTL and testbench

- Two-requester round-robin controller that time-shares the team's 8-bit combinational ALU (packed input {sel[2:0], a[2:0], b[1:0]}, 8-bit result).
- Each requester submits one operation at a time over a valid/ready handshake.
- The block arbitrates, drives the ALU from a register, captures the result and returns it on a response channel with backpressure.
- It sits between the user-facing command sources and the ALU instance; the ALU itself is external.

---
 rtl/alu_rr_sequencer.sv | 135 +++++++++++++
 tb/tb_alu_rr_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_sequencer.sv
// rtl/alu_rr_sequencer.sv - two-requester round-robin sequencer for a shared combinational ALU
module alu_rr_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [7:0]       req0_op,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [7:0]       req1_op,
  output logic             req1_ready,
  output logic [7:0]       alu_in,
  input  logic [7:0]       alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic             rsp_id,
  output logic             busy,
  output logic [CNT_W-1:0] done0_cnt,
  output logic [CNT_W-1:0] done1_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // rr_favour1 = 1 means requester 1 wins the next tie
  logic rr_favour1;
  logic grant_any;
  logic grant_id;
  logic accept;
  logic rsp_fire;

  // Pick a requester: a lone valid wins outright, a tie goes to the favoured side
  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_any = 1'b1;
      grant_id  = rr_favour1;
    end else if (req0_valid) begin
      grant_any = 1'b1;
      grant_id  = 1'b0;
    end else if (req1_valid) begin
      grant_any = 1'b1;
      grant_id  = 1'b1;
    end
  end

  // Next-state decode plus the handshake strobes; readies are forced low during reset
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    rsp_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n && grant_any) begin
          accept     = 1'b1;
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          state_nxt  = EXEC;
        end
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_fire  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign busy = (state != IDLE);

  // Operand capture on accept, result capture after the single execute cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_in     <= 8'h00;
      rsp_id     <= 1'b0;
      rr_favour1 <= 1'b0;
      rsp_data   <= 8'h00;
      rsp_valid  <= 1'b0;
    end else begin
      if (accept) begin
        alu_in     <= grant_id ? req1_op : req0_op;
        rsp_id     <= grant_id;
        rr_favour1 <= ~grant_id;
      end
      if (state == EXEC) begin
        rsp_data  <= alu_out;
        rsp_valid <= 1'b1;
      end else if (rsp_fire) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  // Per-requester delivered-response counters, free-running wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done0_cnt <= '0;
      done1_cnt <= '0;
    end else if (rsp_fire) begin
      if (rsp_id) begin
        done1_cnt <= done1_cnt + CNT_W'(1);
      end else begin
        done0_cnt <= done0_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// tb/tb_alu_rr_sequencer.sv - scoreboard bench for alu_rr_sequencer
module tb_alu_rr_sequencer;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req1_valid;
  logic [7:0]       req0_op, req1_op;
  logic             req0_ready, req1_ready;
  logic [7:0]       alu_in, alu_out;
  logic             rsp_valid, rsp_ready;
  logic [7:0]       rsp_data;
  logic             rsp_id;
  logic             busy;
  logic [CNT_W-1:0] done0_cnt, done1_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_rr_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_ready(req1_ready),
    .alu_in(alu_in), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .busy(busy), .done0_cnt(done0_cnt), .done1_cnt(done1_cnt)
  );

  // Reference ALU: {sel[2:0], a[2:0], b[1:0]}
  function automatic logic [7:0] alu_f(input logic [7:0] op);
    logic [7:0] a;
    logic [7:0] b;
    a = {5'b0, op[4:2]};
    b = {6'b0, op[1:0]};
    case (op[7:5])
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << b;
      3'd6: return a >> b;
      default: return a * b;
    endcase
  endfunction

  always_comb alu_out = alu_f(alu_in);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       id;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];

  // Transaction-level model: a request is either outstanding or not, and
  // its response is due two cycles after the accept.
  bit         m_inflight;
  int         m_lat;
  bit         m_fav1;
  logic [7:0] m_op;
  bit         m_e0, m_e1;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_inflight = 0;
      m_lat      = 0;
      m_fav1     = 0;
      exp_q.delete();
    end else begin
      if (m_inflight) m_lat++;
      m_e0 = 0;
      m_e1 = 0;
      if (!m_inflight) begin
        if (req0_valid && req1_valid) begin
          if (m_fav1) m_e1 = 1; else m_e0 = 1;
        end else if (req0_valid) m_e0 = 1;
        else if (req1_valid) m_e1 = 1;
      end
      chk("req0_ready", req0_ready, m_e0);
      chk("req1_ready", req1_ready, m_e1);
      chk("busy", busy, m_inflight);
      chk("rsp_valid", rsp_valid, m_inflight && m_lat >= 2);
      if (m_inflight && m_lat == 1) chk("alu_in", alu_in, m_op);
      if (m_e0 || m_e1) begin
        m_op = m_e1 ? req1_op : req0_op;
        exp_q.push_back('{id: m_e1, data: alu_f(m_op)});
        m_fav1     = m_e0;
        m_inflight = 1;
        m_lat      = 0;
      end else if (m_inflight && m_lat >= 2 && rsp_ready) begin
        m_inflight = 0;
      end
    end
  end

  // Response monitor: pops the scoreboard on every response handshake
  logic [CNT_W-1:0] exp_cnt0, exp_cnt1;
  exp_t             mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_cnt0 = '0;
      exp_cnt1 = '0;
    end else begin
      chk("done0_cnt", done0_cnt, exp_cnt0);
      chk("done1_cnt", done1_cnt, exp_cnt1);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got id %0d data %0h expected none", rsp_id, rsp_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_data", rsp_data, mon_e.data);
          chk("rsp_id", rsp_id, mon_e.id);
          if (mon_e.id) exp_cnt1 = exp_cnt1 + 1'b1;
          else exp_cnt0 = exp_cnt0 + 1'b1;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v0, input logic [7:0] o0, input logic v1, input logic [7:0] o1);
    req0_valid = v0;
    req0_op    = o0;
    req1_valid = v1;
    req1_op    = o1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_rsp(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: got no rsp_valid expected within %0d cycles", budget);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    set_req(0, 8'h00, 0, 8'h00);
    tick(2);

    // Reset state, with requests pending to show readies are held low
    set_req(1, 8'h17, 1, 8'hBF);
    #1;
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_alu_in", alu_in, 8'h00);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done0", done0_cnt, 0);
    chk("rst_done1", done1_cnt, 0);
    set_req(0, 8'h00, 0, 8'h00);
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // Single op followed by 5 cycles of backpressure
    set_req(1, 8'h17, 0, 8'h00);
    tick(1);
    chk("single_alu_in", alu_in, 8'h17);
    chk("single_busy", busy, 1);
    set_req(0, 8'h00, 0, 8'h00);
    wait_rsp(5);
    chk("single_rsp_data", rsp_data, 8'h08);
    chk("single_rsp_id", rsp_id, 0);
    set_req(0, 8'h00, 1, 8'hBF);
    repeat (5) begin
      @(negedge clk);
      chk("bp_rsp_data", rsp_data, 8'h08);
      chk("bp_rsp_id", rsp_id, 0);
      chk("bp_req1_ready", req1_ready, 0);
      chk("bp_busy", busy, 1);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    tick(1);
    chk("single_done0", done0_cnt, 1);
    chk("bp_next_accept", req1_ready, 1);
    tick(1);
    set_req(0, 8'h00, 0, 8'h00);
    tick(4);
    chk("bp_done1", done1_cnt, 1);

    // Contention: both held valid, grants must alternate
    do_reset();
    rsp_ready = 1'b1;
    set_req(1, 8'h3D, 1, 8'hBF);
    tick(12);
    set_req(0, 8'h00, 0, 8'h00);
    tick(2);
    chk("cont_done0", done0_cnt, 2);
    chk("cont_done1", done1_cnt, 2);

    // Wrap-around of done1_cnt with a borrow result
    do_reset();
    rsp_ready = 1'b1;
    set_req(0, 8'h00, 1, 8'h26);
    tick(765);
    chk("wrap_done1_ff", done1_cnt, 8'hFF);
    tick(3);
    set_req(0, 8'h00, 0, 8'h00);
    tick(2);
    chk("wrap_done1_0", done1_cnt, 8'h00);
    chk("wrap_done0", done0_cnt, 8'h00);

    // Async reset while holding a response
    do_reset();
    rsp_ready = 1'b0;
    set_req(1, 8'h17, 0, 8'h00);
    tick(1);
    set_req(0, 8'h00, 0, 8'h00);
    wait_rsp(5);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    set_req(1, 8'h3D, 1, 8'hBF);
    #1;
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_req0_ready", req0_ready, 0);
    chk("arst_req1_ready", req1_ready, 0);
    chk("arst_done0", done0_cnt, 0);
    chk("arst_alu_in", alu_in, 8'h00);
    tick(1);
    rsp_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    chk("arst_rr_req0", req0_ready, 1);
    chk("arst_rr_req1", req1_ready, 0);
    tick(1);
    set_req(0, 8'h00, 1, 8'hBF);
    tick(3);
    set_req(0, 8'h00, 0, 8'h00);
    tick(4);
    chk("arst_done0_after", done0_cnt, 1);
    chk("arst_done1_after", done1_cnt, 1);

    // Idle stability
    repeat (20) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_rsp_valid", rsp_valid, 0);
      chk("idle_alu_in", alu_in, 8'hBF);
    end

    // Randomized traffic against the model
    tick(1);
    for (int i = 0; i < 400; i++) begin
      set_req(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom));
      rsp_ready = ($urandom_range(0, 9) < 7);
      tick(1);
    end
    set_req(0, 8'h00, 0, 8'h00);
    rsp_ready = 1'b1;
    tick(6);
    chk("drain_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
